// File: rtl/led_encoder_capture.sv
// Recovers the characters shown on a multiplexed 4-digit 7-segment display by watching
// its anode and segment lines, and presents each complete set of four digits as one frame.
module led_encoder_capture #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  LED,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [15:0] frame_char,
  output logic [3:0]  frame_err,
  output logic        overrun
);

  typedef enum logic [1:0] {SCAN, SETTLE, HOLD} state_t;

  localparam logic [7:0] STABLE_L = 8'(STABLE_CYCLES);

  state_t      state_reg;
  logic [10:0] ref_reg;
  logic [7:0]  cnt_reg;
  logic [15:0] slot_code_reg;
  logic [3:0]  slot_err_reg;
  logic [3:0]  seen_reg;

  logic [10:0] cur;
  logic        an_valid;
  logic [1:0]  idx;
  logic [3:0]  dec_code;
  logic        dec_err;
  logic        capture;
  logic [3:0]  seen_cap;
  logic        complete;
  logic [15:0] slot_code_next;
  logic [3:0]  slot_err_next;

  assign cur = {an, LED};

  // Exactly one active-low enable selects a digit; anything else is ignored.
  always_comb begin
    an_valid = 1'b1;
    idx      = 2'd0;
    case (an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: an_valid = 1'b0;
    endcase
  end

  always_comb begin
    dec_err  = 1'b0;
    dec_code = 4'hF;
    case (LED)
      7'b0000001: dec_code = 4'h0;
      7'b1001111: dec_code = 4'h1;
      7'b0010010: dec_code = 4'h2;
      7'b0000110: dec_code = 4'h3;
      7'b1001100: dec_code = 4'h4;
      7'b0100100: dec_code = 4'h5;
      7'b0100000: dec_code = 4'h6;
      7'b0001111: dec_code = 4'h7;
      7'b0000000: dec_code = 4'h8;
      7'b0000100: dec_code = 4'h9;
      7'b1111110: dec_code = 4'hB;
      7'b0111000: dec_code = 4'hC;
      7'b1111111: dec_code = 4'hF;
      default:    dec_err  = 1'b1;
    endcase
  end

  // The digit is taken on the cycle the run of identical samples reaches the threshold.
  assign capture = (state_reg == SETTLE) && (cur == ref_reg) &&
                   ((cnt_reg + 8'd1) == STABLE_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SCAN;
      cnt_reg   <= 8'd0;
      ref_reg   <= 11'd0;
    end else begin
      case (state_reg)
        SCAN: begin
          if (an_valid) begin
            ref_reg   <= cur;
            cnt_reg   <= 8'd1;
            state_reg <= SETTLE;
          end
        end
        SETTLE: begin
          if (cur == ref_reg) begin
            cnt_reg <= cnt_reg + 8'd1;
            if ((cnt_reg + 8'd1) == STABLE_L) state_reg <= HOLD;
          end else if (an_valid) begin
            ref_reg <= cur;
            cnt_reg <= 8'd1;
          end else begin
            state_reg <= SCAN;
          end
        end
        HOLD: begin
          // Leaving the dwell acts like SCAN immediately so no sample is lost.
          if (cur != ref_reg) begin
            if (an_valid) begin
              ref_reg   <= cur;
              cnt_reg   <= 8'd1;
              state_reg <= SETTLE;
            end else begin
              state_reg <= SCAN;
            end
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic hit;
      assign hit                        = capture && (idx == 2'(gi));
      assign slot_code_next[4*gi +: 4]  = hit ? dec_code : slot_code_reg[4*gi +: 4];
      assign slot_err_next[gi]          = hit ? dec_err  : slot_err_reg[gi];
      assign seen_cap[gi]               = seen_reg[gi] | hit;
    end
  endgenerate

  assign complete = (seen_cap == 4'b1111);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_code_reg <= 16'hFFFF;
      slot_err_reg  <= 4'd0;
      seen_reg      <= 4'd0;
      frame_valid   <= 1'b0;
      frame_char    <= 16'hFFFF;
      frame_err     <= 4'd0;
      overrun       <= 1'b0;
    end else begin
      slot_code_reg <= slot_code_next;
      slot_err_reg  <= slot_err_next;
      seen_reg      <= complete ? 4'd0 : seen_cap;
      overrun       <= 1'b0;
      if (complete) begin
        if (!frame_valid || frame_ready) begin
          frame_valid <= 1'b1;
          frame_char  <= slot_code_next;
          frame_err   <= slot_err_next;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_encoder_capture.sv
// Directed bench for led_encoder_capture: a run-length reference model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_led_encoder_capture;

  localparam int STABLE = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an = 4'b1111;
  logic [6:0]  LED = 7'b1111111;
  logic        frame_ready = 1'b1;
  logic        frame_valid;
  logic [15:0] frame_char;
  logic [3:0]  frame_err;
  logic        overrun;

  led_encoder_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .an(an), .LED(LED), .frame_ready(frame_ready),
    .frame_valid(frame_valid), .frame_char(frame_char), .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110,
                         P4 = 7'b1001100, PDASH = 7'b1111110, PF = 7'b0111000,
                         PBLANK = 7'b1111111, P8 = 7'b0000000, PBAD = 7'b1010101;

  localparam logic [6:0] PAT [13] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100, 7'b1111110, 7'b0111000,
                                      7'b1111111};
  localparam logic [3:0] CODE [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                       4'h8, 4'h9, 4'hB, 4'hC, 4'hF};

  int vectors = 0;
  int miscompares = 0;
  int fv_rises = 0;
  int ovr_pulses = 0;

  // Reference model: a digit is captured when the same valid {an,LED} has been seen for
  // exactly STABLE consecutive cycles; frames form whenever all four digits were seen.
  logic [10:0] m_prev;
  bit          m_prev_ok;
  int          m_run;
  logic [3:0]  m_code [4];
  logic [3:0]  m_err;
  logic [3:0]  m_seen;
  logic        exp_fv;
  logic [15:0] exp_char;
  logic [3:0]  exp_err;
  logic        exp_ovr;

  always @(posedge clk) begin
    if (reset) begin
      m_prev_ok = 0; m_run = 0; m_err = 0; m_seen = 0;
      for (int i = 0; i < 4; i++) m_code[i] = 4'hF;
      exp_fv = 0; exp_char = 16'hFFFF; exp_err = 0; exp_ovr = 0;
    end else begin
      logic old_fv;
      old_fv  = exp_fv;
      exp_ovr = 0;
      if ($countones(~an) == 1) begin
        if (m_prev_ok && {an, LED} == m_prev) m_run++;
        else m_run = 1;
        m_prev = {an, LED};
        m_prev_ok = 1;
        if (m_run == STABLE) begin
          int d;
          logic [3:0] c;
          logic e;
          d = 0;
          for (int i = 0; i < 4; i++) if (!an[i]) d = i;
          c = 4'hF; e = 1;
          for (int k = 0; k < 13; k++) if (LED == PAT[k]) begin c = CODE[k]; e = 0; end
          m_code[d] = c; m_err[d] = e; m_seen[d] = 1'b1;
        end
      end else begin
        m_prev_ok = 0;
        m_run = 0;
      end
      if (m_seen == 4'hF) begin
        m_seen = 0;
        if (!old_fv || frame_ready) begin
          exp_fv = 1;
          exp_char = {m_code[3], m_code[2], m_code[1], m_code[0]};
          exp_err = m_err;
        end else begin
          exp_ovr = 1;
        end
      end else if (old_fv && frame_ready) begin
        exp_fv = 0;
      end
    end
  end

  logic prev_fv = 1'b0;
  always @(negedge clk) begin
    vectors++;
    if (frame_valid !== exp_fv || frame_char !== exp_char ||
        frame_err !== exp_err || overrun !== exp_ovr) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t got fv=%b char=%h err=%b ovr=%b want fv=%b char=%h err=%b ovr=%b",
               $time, frame_valid, frame_char, frame_err, overrun,
               exp_fv, exp_char, exp_err, exp_ovr);
    end
    if (frame_valid && !prev_fv) fv_rises++;
    if (overrun) ovr_pulses++;
    prev_fv = frame_valid;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] l, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      an = a; LED = l;
    end
  endtask

  task automatic scan4(input logic [6:0] l0, l1, l2, l3, input int n);
    drive(4'b1110, l0, n);
    drive(4'b1101, l1, n);
    drive(4'b1011, l2, n);
    drive(4'b0111, l3, n);
    drive(4'b1111, PBLANK, 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; an = 4'b1111; LED = PBLANK;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int r0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_fv", 32'(frame_valid), 32'd0);
    check("reset_char", 32'(frame_char), 32'hFFFF);
    check("reset_err_ovr", {27'd0, frame_err, overrun}, 32'd0);

    // Digits "1234" scanned with a ready consumer.
    scan4(P1, P2, P3, P4, 20);
    check("basic_char", 32'(frame_char), 32'h4321);
    check("basic_err", 32'(frame_err), 32'h0);
    check("basic_rises", 32'(fv_rises), 32'd1);
    check("basic_accepted", 32'(frame_valid), 32'd0);

    // A 15-cycle dwell on digit 0 must not capture it.
    do_reset();
    r0 = fv_rises;
    drive(4'b1110, P1, STABLE - 1);
    drive(4'b1101, P2, 20);
    drive(4'b1011, P3, 20);
    drive(4'b0111, P4, 20);
    drive(4'b1111, PBLANK, 3);
    check("short_dwell_rises", 32'(fv_rises - r0), 32'd0);

    // Invalid anodes ignored, then "-", "F", blank, "8".
    do_reset();
    r0 = fv_rises;
    drive(4'b0011, P8, 40);
    check("bad_anode_rises", 32'(fv_rises - r0), 32'd0);
    scan4(PDASH, PF, PBLANK, P8, 20);
    check("symbols_char", 32'(frame_char), 32'h8FCB);
    check("symbols_err", 32'(frame_err), 32'h0);

    // Unrecognised pattern on digit 2.
    do_reset();
    scan4(P1, P2, PBAD, P4, 20);
    check("bad_pat_err", 32'(frame_err), 32'b0100);
    check("bad_pat_nib", 32'(frame_char[11:8]), 32'hF);

    // Back-pressure: second frame dropped with a single overrun pulse.
    do_reset();
    frame_ready = 1'b0;
    r0 = ovr_pulses;
    scan4(P1, P2, P3, P4, 20);
    scan4(PDASH, PF, PBLANK, P8, 20);
    check("held_fv", 32'(frame_valid), 32'd1);
    check("held_char", 32'(frame_char), 32'h4321);
    check("overrun_once", 32'(ovr_pulses - r0), 32'd1);
    frame_ready = 1'b1;
    @(negedge clk);
    check("accepted_fv", 32'(frame_valid), 32'd0);

    // Reset during the settle of digit 3 discards everything.
    do_reset();
    drive(4'b1110, P1, 20);
    drive(4'b1101, P2, 20);
    drive(4'b1011, P3, 20);
    drive(4'b0111, P4, 8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_char", 32'(frame_char), 32'hFFFF);
    check("midreset_fv_err", {27'd0, frame_valid, frame_err}, 32'd0);
    reset = 1'b0;
    r0 = fv_rises;
    drive(4'b0111, P4, 20);
    drive(4'b1111, PBLANK, 3);
    check("midreset_no_frame", 32'(fv_rises - r0), 32'd0);
    scan4(P1, P2, P3, P4, 20);
    check("midreset_rescan", 32'(fv_rises - r0), 32'd1);
    check("midreset_char2", 32'(frame_char), 32'h4321);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_encoder_capture.md
LED_ENCODER_CAPTURE -- requirements
Module: led_encoder_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, is the number of consecutive identical cycles required before a digit is captured (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 an  input  4  active-low digit enables; an[i]=0 selects digit i.
REQ-005 LED  input  7  active-low segments {a,b,c,d,e,f,g}; bit 6 is a.
REQ-006 frame_ready  input  1  consumer accepts the frame when high together with frame_valid.
REQ-007 frame_valid  output  1  a complete 4-digit frame is held on frame_char/frame_err.
REQ-008 frame_char  output  16  recovered 4-bit codes; digit i at bits [4i+3:4i].
REQ-009 frame_err  output  4  frame_err[i]=1: digit i pattern was unrecognized.
REQ-010 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-011 Pattern-to-code map: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111110->4'hB, 0111000->4'hC, 1111111->4'hF.
REQ-012 Any other LED pattern yields code 4'hF with err bit 1.
REQ-013 An anode vector is valid only if exactly one bit is 0; all other vectors (including 4'b1111) are invalid.
REQ-014 Capture FSM states: SCAN, SETTLE, HOLD.
REQ-015 SCAN: on valid anode, latch {an, LED} as reference, counter=1, go SETTLE; otherwise stay.
REQ-016 SETTLE: if {an, LED} equals reference, counter increments; on reaching STABLE_CYCLES, capture digit and go HOLD.
REQ-017 SETTLE: on any change of {an, LED}, if new anode valid restart with new reference and counter=1, else go SCAN.
REQ-018 HOLD: remain until {an, LED} differs from reference; then behave as SCAN in that same cycle (no digit captured twice per dwell).
REQ-019 Capture writes code and err into digit slot i and sets seen[i]; a re-captured digit overwrites its slot.
REQ-020 When seen==4'b1111 at a cycle end (including the capture cycle), the frame is complete: seen clears to 0.
REQ-021 Complete frame with output register empty, or being accepted this cycle (frame_valid & frame_ready): load frame_char/frame_err, frame_valid=1 next cycle.
REQ-022 Complete frame with output register full and not accepted this cycle: frame discarded, overrun=1 for exactly one cycle, outputs unchanged.
REQ-023 frame_valid, frame_char and frame_err are stable while frame_valid=1 and frame_ready=0.
REQ-024 frame_valid & frame_ready with no new frame: frame_valid=0 next cycle.
REQ-025 Latency: digit captured STABLE_CYCLES cycles after its first stable cycle; frame_valid rises the cycle after the fourth capture.

Reset
REQ-026 reset high: FSM=SCAN, counter=0, seen=0, digit slots=4'hF/err 0, frame_valid=0, frame_char=16'hFFFF, frame_err=0, overrun=0.
REQ-027 reset has priority over all events; reset mid-SETTLE or with frame pending discards all partial and pending data.

Verification
REQ-028 Scan digits 0..3 with "1","2","3","4" patterns, 20 cycles each, ready=1 -> frame_valid pulse, frame_char=16'h4321, frame_err=0.
REQ-029 Dwell digit 0 only 15 cycles (STABLE_CYCLES=16) then move on -> digit 0 not captured, no frame_valid.
REQ-030 an=4'b0011 held 40 cycles -> no capture; then legal scan of "-","F",blank,"8" -> frame_char=16'h8FCB.
REQ-031 LED=7'b1010101 on digit 2 -> frame_err=4'b0100, frame_char[11:8]=4'hF.
REQ-032 ready=0, two full frames scanned -> first frame held unchanged, overrun pulses once at second completion; ready=1 -> first frame accepted, frame_valid=0.
REQ-033 reset asserted in SETTLE of digit 3 after digits 0-2 captured -> all outputs at reset values; next full scan needed for frame_valid.
